blob_motion: RTL and testbench
==============================

// Module: blob_motion
// PURPOSE
//  Per-frame position engine for a rectangular sprite. Once per video frame, on the vsync
//  falling edge, it steps the sprite's top-left corner (x,y).
//  The step is set by button direction and a speed setting. The sprite bounces off the
//  screen edges. x,y feed the sprite renderer's x/y inputs directly; vclock domain only.
// PARAMETERS
//  WIDTH      64    sprite width in pixels (must match renderer)
//  HEIGHT     64    sprite height in pixels (must match renderer)
//  SCREEN_W   1024  visible pixels per line
//  SCREEN_H   768   visible lines per frame
//  X_INIT     480   reset x (must be <= SCREEN_W-WIDTH)
//  Y_INIT     352   reset y (must be <= SCREEN_H-HEIGHT)
//  MAX_SPEED  7     step clamp, pixels/frame (1..15)
// PORTS
//  vclock     in   1   pixel clock; all state on rising edge
//  reset      in   1   asynchronous, active-high
//  vsync      in   1   active-low vertical sync from timing generator
//  pause      in   1   1 = hold position this frame
//  speed      in   4   requested step, pixels/frame
//  btn_left   in   1   force x direction negative (synchronised/debounced upstream)
//  btn_right  in   1   force x direction positive
//  btn_up     in   1   force y direction negative
//  btn_down   in   1   force y direction positive
//  x          out  11  sprite left edge, 0..SCREEN_W-WIDTH
//  y          out  10  sprite top edge, 0..SCREEN_H-HEIGHT
//  bounce     out  1   one-cycle pulse: a wall was hit this frame
// BEHAVIOUR
//  Reset (async, any state):
//   x=X_INIT, y=Y_INIT, dx_neg=0, dy_neg=0, bounce=0, state=IDLE, vsync_d=1.
//  Edge detect: vsync_d registers vsync; a detect cycle is vsync_d==1 && vsync==0.
//  FSM IDLE -> LATCH -> STEP_X -> STEP_Y -> COMMIT -> IDLE (one cycle each except IDLE).
//   IDLE: leaves only on a detect cycle with pause==0. pause==1 at detect -> frame skipped.
//   LATCH: captures step = min(speed, MAX_SPEED) and the buttons.
//    Direction override: left&!right -> dx_neg=1; right&!left -> dx_neg=0; both/none -> keep.
//    Same rule for up/down on dy_neg.
//   STEP_X: computes nx from x in 12-bit unsigned arithmetic (no wrap).
//    Positive: if x+step > SCREEN_W-WIDTH, then nx=SCREEN_W-WIDTH, dx_neg=1, hit.
//    Negative: if x < step, then nx=0, dx_neg=0, hit.
//    Otherwise nx = x +/- step.
//   STEP_Y: same rule for ny from y, SCREEN_H-HEIGHT, dy_neg.
//   COMMIT: x<=nx and y<=ny in the same cycle, so the renderer never sees a half update.
//    bounce<=1 for this one cycle if either axis hit.
//  Latency: x/y/bounce change on the 4th rising edge after the detect edge.
//  step==0: no movement, no hit, no bounce, direction override still applied.
//  A wall hit clamps exactly to the wall. A held button re-forces the direction the next
//   frame, so the sprite sits at the wall and pulses bounce every frame.
//  A detect cycle while not IDLE is ignored; speed/button changes after LATCH are ignored.
//  Reset mid-FSM: aborts, no bounce pulse, pending nx/ny discarded.
//  bounce is 0 in every cycle other than COMMIT.
// TESTING
//  T1 reset -> x=480, y=352, bounce=0; outputs hold with vsync static high.
//  T2 speed=4, no buttons, 10 vsync falls -> x=520, y=392, bounce never asserted;
//     each update lands exactly 4 clocks after the detect edge.
//  T3 X_INIT=955, Y_INIT=100, speed=7, 1 frame -> x=960, y=107, bounce pulse 1 cycle;
//     next frame -> x=953, y=114.
//  T4 X_INIT=3, btn_left held, speed=5 -> x=0, bounce;
//     next frame -> x=0, bounce again; release btn_left -> x=5.
//  T5 pause=1 at edge -> x/y unchanged; speed=0 -> unchanged, no bounce;
//     speed=12 -> step 7; left+right held together -> dx unchanged.
//  T6 reset asserted in STEP_Y -> x=480, y=352 immediately, no bounce;
//     next edge with speed=2 -> x=482, y=354.

Source files
------------

// File: rtl/blob_motion.sv
// blob_motion: once-per-frame position engine for a rectangular sprite.
// A vsync falling edge launches a short sequence that latches the speed and
// buttons, steps each axis with wall bouncing, then commits x and y together.
module blob_motion #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int SCREEN_W  = 1024,
  parameter int SCREEN_H  = 768,
  parameter int X_INIT    = 480,
  parameter int Y_INIT    = 352,
  parameter int MAX_SPEED = 7
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pause,
  input  logic [3:0]  speed,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        bounce
);

  // Largest legal top-left coordinates: the sprite's far edge sits on the wall
  localparam logic [11:0] X_MAX    = 12'(SCREEN_W - WIDTH);
  localparam logic [11:0] Y_MAX    = 12'(SCREEN_H - HEIGHT);
  localparam logic [3:0]  MAX_STEP = 4'(MAX_SPEED);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    STEP_X = 3'd2,
    STEP_Y = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        vsync_d;
  logic        detect;
  logic [3:0]  step;
  logic [3:0]  step_clamped;
  logic        dx_neg, dy_neg;
  logic [10:0] nx;
  logic [9:0]  ny;
  logic        hit_x, hit_y;
  logic [11:0] x_sum, y_sum;
  logic [11:0] x_wide, y_wide, step_wide;

  assign detect       = vsync_d & ~vsync;
  assign step_clamped = (speed > MAX_STEP) ? MAX_STEP : speed;
  // 12-bit operands so x+step can never wrap before the wall comparison
  assign x_wide       = {1'b0, x};
  assign y_wide       = {2'b00, y};
  assign step_wide    = {8'd0, step};
  assign x_sum        = x_wide + step_wide;
  assign y_sum        = y_wide + step_wide;

  // Delay vsync by one cycle for falling-edge detection
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) vsync_d <= 1'b1;
    else       vsync_d <= vsync;
  end

  // FSM state register
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: a paused frame or a mid-sequence vsync edge is ignored
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (detect && !pause) state_next = LATCH;
      LATCH:   state_next = STEP_X;
      STEP_X:  state_next = STEP_Y;
      STEP_Y:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch inputs, step each axis with bounce, commit both together
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      x      <= 11'(X_INIT);
      y      <= 10'(Y_INIT);
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
      bounce <= 1'b0;
      step   <= 4'd0;
      nx     <= 11'd0;
      ny     <= 10'd0;
      hit_x  <= 1'b0;
      hit_y  <= 1'b0;
    end else begin
      bounce <= 1'b0;
      case (state)
        LATCH: begin
          step <= step_clamped;
          if (btn_left && !btn_right)      dx_neg <= 1'b1;
          else if (btn_right && !btn_left) dx_neg <= 1'b0;
          if (btn_up && !btn_down)         dy_neg <= 1'b1;
          else if (btn_down && !btn_up)    dy_neg <= 1'b0;
        end
        STEP_X: begin
          hit_x <= 1'b0;
          if (!dx_neg) begin
            if (x_sum > X_MAX) begin
              nx     <= X_MAX[10:0];
              dx_neg <= 1'b1;
              hit_x  <= 1'b1;
            end else begin
              nx <= x_sum[10:0];
            end
          end else begin
            if (x_wide < step_wide) begin
              nx     <= 11'd0;
              dx_neg <= 1'b0;
              hit_x  <= 1'b1;
            end else begin
              nx <= x - {7'd0, step};
            end
          end
        end
        STEP_Y: begin
          hit_y <= 1'b0;
          if (!dy_neg) begin
            if (y_sum > Y_MAX) begin
              ny     <= Y_MAX[9:0];
              dy_neg <= 1'b1;
              hit_y  <= 1'b1;
            end else begin
              ny <= y_sum[9:0];
            end
          end else begin
            if (y_wide < step_wide) begin
              ny     <= 10'd0;
              dy_neg <= 1'b0;
              hit_y  <= 1'b1;
            end else begin
              ny <= y - {6'd0, step};
            end
          end
        end
        COMMIT: begin
          x      <= nx;
          y      <= ny;
          bounce <= hit_x | hit_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_motion.sv
// tb_blob_motion: directed and randomized frames against a per-frame
// position model of the sprite (clamped step, direction override, bounce).
module tb_blob_motion;

  logic        vclock;
  logic        reset;
  logic        vsync;
  logic        pause;
  logic [3:0]  speed;
  logic        btn_left, btn_right, btn_up, btn_down;
  logic [10:0] x;
  logic [9:0]  y;
  logic        bounce;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int  mx, my;
  bit  mdxn, mdyn;

  blob_motion dut (
    .vclock    (vclock),
    .reset     (reset),
    .vsync     (vsync),
    .pause     (pause),
    .speed     (speed),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .x         (x),
    .y         (y),
    .bounce    (bounce)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 480; my = 352; mdxn = 0; mdyn = 0;
  endtask

  // One frame of sprite motion; returns whether a wall was hit
  function automatic bit model_frame(input int spd, input bit l, input bit r,
                                     input bit u, input bit d);
    int  st;
    bit  hit;
    st  = (spd > 7) ? 7 : spd;
    hit = 0;
    if (l && !r) mdxn = 1; else if (r && !l) mdxn = 0;
    if (u && !d) mdyn = 1; else if (d && !u) mdyn = 0;
    if (mdxn) begin
      if (mx < st) begin mx = 0; mdxn = 0; hit = 1; end
      else mx = mx - st;
    end else begin
      if (mx + st > 960) begin mx = 960; mdxn = 1; hit = 1; end
      else mx = mx + st;
    end
    if (mdyn) begin
      if (my < st) begin my = 0; mdyn = 0; hit = 1; end
      else my = my - st;
    end else begin
      if (my + st > 704) begin my = 704; mdyn = 1; hit = 1; end
      else my = my + st;
    end
    return hit;
  endfunction

  // Drive one vsync fall and check timing; inputs are scrambled after latch
  task automatic do_frame(input bit p, input int spd, input bit l, input bit r,
                          input bit u, input bit d, input bit mid_reset);
    int  ox, oy;
    bit  hit;
    ox = mx; oy = my;
    @(negedge vclock);
    pause = p; speed = 4'(spd);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d;
    vsync = 1'b0;
    @(posedge vclock);                       // detect edge
    @(negedge vclock);
    vsync = 1'b1;
    pause = 1'($urandom_range(0, 1));
    @(posedge vclock);                       // latch edge
    @(negedge vclock);
    speed = 4'($urandom_range(0, 15));
    btn_left = 1'($urandom_range(0, 1)); btn_right = 1'($urandom_range(0, 1));
    btn_up   = 1'($urandom_range(0, 1)); btn_down  = 1'($urandom_range(0, 1));
    if (!p) vsync = 1'b0;                    // stray edge while busy
    @(posedge vclock);
    @(negedge vclock);
    vsync = 1'b1;
    if (mid_reset && !p) begin
      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_x", 32'(x), 32'(mx));
      chk("midrst_y", 32'(y), 32'(my));
      chk("midrst_bounce", 32'(bounce), 32'd0);
      @(negedge vclock);
      reset = 1'b0;
      pause = 1'b0;
      repeat (2) @(negedge vclock);
      return;
    end
    @(posedge vclock);
    @(negedge vclock);
    chk("pre_commit_x", 32'(x), 32'(ox));
    chk("pre_commit_bounce", 32'(bounce), 32'd0);
    @(posedge vclock);                       // 4th edge after detect
    @(negedge vclock);
    hit = 0;
    if (!p) hit = model_frame(spd, l, r, u, d);
    chk("commit_x", 32'(x), 32'(mx));
    chk("commit_y", 32'(y), 32'(my));
    chk("commit_bounce", 32'(bounce), 32'(hit));
    @(posedge vclock);
    @(negedge vclock);
    chk("post_bounce", 32'(bounce), 32'd0);
    pause = 1'b0;
    repeat (2) @(negedge vclock);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; pause = 1'b0; speed = 4'd0;
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    model_reset();
    repeat (2) @(negedge vclock);
    chk("rst_x", 32'(x), 32'd480);
    chk("rst_y", 32'(y), 32'd352);
    chk("rst_bounce", 32'(bounce), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge vclock);
    chk("idle_x", 32'(x), 32'd480);
    chk("idle_y", 32'(y), 32'd352);

    // Ten plain frames at speed 4
    for (int i = 0; i < 10; i++) do_frame(0, 4, 0, 0, 0, 0, 0);
    chk("t2_x", 32'(x), 32'd520);
    chk("t2_y", 32'(y), 32'd392);

    // Pause, zero speed, over-range speed, opposing buttons
    do_frame(1, 5, 1, 0, 1, 0, 0);
    chk("pause_x", 32'(x), 32'd520);
    do_frame(0, 0, 1, 0, 0, 0, 0);
    chk("speed0_x", 32'(x), 32'd520);
    do_frame(0, 12, 0, 0, 0, 0, 0);
    chk("speed12_x", 32'(x), 32'd513);
    do_frame(0, 3, 1, 1, 0, 0, 0);
    chk("lr_both_x", 32'(x), 32'd510);

    // Drive into the left/top walls and sit there, then release
    for (int i = 0; i < 80; i++) do_frame(0, 15, 1, 0, 1, 0, 0);
    chk("wall_left_x", 32'(x), 32'd0);
    chk("wall_top_y", 32'(y), 32'd0);
    do_frame(0, 5, 0, 0, 0, 0, 0);
    chk("release_x", 32'(x), 32'd5);

    // Drive into the right/bottom walls
    for (int i = 0; i < 140; i++) do_frame(0, 15, 0, 1, 0, 1, 0);
    chk("wall_right_x", 32'(x), 32'd960);
    chk("wall_bottom_y", 32'(y), 32'd704);

    // Reset while stepping, then a speed-2 frame
    do_frame(0, 6, 0, 0, 0, 0, 1);
    do_frame(0, 2, 0, 0, 0, 0, 0);
    chk("t6_x", 32'(x), 32'd482);
    chk("t6_y", 32'(y), 32'd354);

    // Randomized frames
    for (int i = 0; i < 200; i++) begin
      do_frame(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
